alu_src_sel_pipe: RTL and testbench
===================================

// Module: alu_src_sel_pipe
// PURPOSE
//   Parametrised, registered operand selector for the ALU source path.
//   - Picks one of NSRC WIDTH-bit sources by selector; any code >= NSRC yields constant 0.
//   - Result sits in a 1-deep output register with a 1-entry skid buffer, behind a valid/ready handshake.
//   - Sits between the datapath register file/PC/MDR outputs and the ALU operand input; the control unit drives selector.
// PARAMETERS
//   WIDTH  32  data width of each source and of data_out
//   NSRC   2   number of data sources, 1..(2**SELW)-1
//   SELW   2   selector width; 2**SELW > NSRC required (at least one zero code)
// PORTS
//   clk        in   1           system clock, rising edge
//   reset      in   1           synchronous, active-high reset
//   in_valid   in   1           selector/data_in valid this cycle
//   in_ready   out  1           block can accept this cycle
//   selector   in   SELW        source select; k<NSRC -> source k, else 0
//   data_in    in   NSRC*WIDTH  packed sources; source k = data_in[k*WIDTH +: WIDTH]
//   out_valid  out  1           data_out holds a selected operand
//   out_ready  in   1           consumer takes data_out this cycle
//   data_out   out  WIDTH       selected operand, registered
//   out_zero   out  1           registered; 1 when data_out == 0
//   sel_err    out  1           only with ALU_SRC_SELERR_EN; see CONFIGURATION
// BEHAVIOUR
//   - Storage: main reg (drives data_out/out_zero/out_valid) + skid reg (skid_valid).
//   - in_ready = !skid_valid && !reset. Accept = in_valid && in_ready. Consume = out_valid && out_ready.
//   - Selection is combinational at the input; the selected value, not the selector, is stored.
//     Sources are sampled only on the accept cycle.
//   - Latency: accept in cycle N -> data_out/out_valid visible in cycle N+1 (main empty or consumed in N).
//   - Main empty, or consumed this cycle:
//     - skid_valid=1: skid moves to main; an accept loads skid.
//     - skid_valid=0: an accept loads main; with no accept, out_valid falls to 0 if consumed.
//   - Main full, not consumed, accept: word goes to skid; in_ready = 0 next cycle.
//   - Simultaneous accept + consume with skid empty: main reloads, out_valid stays 1, no bubble (full rate).
//   - Full (main+skid, no consume): in_ready=0; in_valid ignored; all state held.
//   - Ordering: strict FIFO, no word dropped or duplicated; data_out stable while out_valid && !out_ready.
//   - Reset (any cycle, incl. mid-transfer): next edge clears everything.
//     - out_valid=0, skid_valid=0, data_out=0, out_zero=1, sel_err=0.
//     - Stored words are discarded; in_ready=0 while reset is high, 1 in the first cycle after.
//   - Zero codes: NSRC..2**SELW-1 all select 32'd0 (WIDTH'd0). With NSRC=2, SELW=2, codes 00/01/10/11 give src0/src1/0/0.
//   - Elaboration check: $error if NSRC<1 or 2**SELW<=NSRC.
// CONFIGURATION
//   ALU_SRC_SELERR_EN defined:
//     - sel_err port exists; sticky, set on the edge after an accept whose selector >= NSRC+1.
//     - NSRC itself is the legal zero code.
//     - Cleared only by reset.
//   ALU_SRC_SELERR_EN undefined:
//     - No sel_err port, no logic.
//     - All codes >= NSRC silently select 0.
// TESTING
//   1 Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, data_out=0, out_zero=1, in_ready=0; in_ready=1 the cycle after release.
//   2 Select (NSRC=2,SELW=2), out_ready=1: sel 0,1,2 with src0=0xDEADBEEF, src1=0x00000004
//     -> data_out 0xDEADBEEF, 0x4, 0x0 on successive cycles; out_zero only on the third.
//   3 Backpressure: out_ready=0, push A,B,C -> A,B accepted, in_ready=0 after B, C held off.
//     Raise out_ready -> A, B, C emerge in order, one per cycle.
//   4 Full rate: in_valid=out_ready=1 for 16 cycles with incrementing src0 -> 16 outputs, no bubbles, in_ready never 0.
//   5 Reset mid-op: main+skid full, assert reset 1 cycle -> stored words lost; next input is the first output.
//   6 ALU_SRC_SELERR_EN, NSRC=2, SELW=2: accept sel=3 -> data_out=0, sel_err=1 next edge, stays 1 through sel=0 traffic until reset.

Source files
------------

// File: rtl/alu_src_sel_pipe.sv
// Registered ALU operand selector: NSRC sources, zero for out-of-range codes, valid/ready with 1-entry skid.
// Optional sticky sel_err output when ALU_SRC_SELERR_EN is defined.
module alu_src_sel_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned SELW  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       selector,
    input  logic [NSRC*WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      data_out,
    output logic                  out_zero
`ifdef ALU_SRC_SELERR_EN
    ,
    output logic                  sel_err
`endif
);

    generate
        if ((NSRC < 1) || ((1 << SELW) <= NSRC)) begin : g_param_check
            $error("alu_src_sel_pipe: need 1 <= NSRC < 2**SELW");
        end
    endgenerate

    logic [WIDTH-1:0] sel_val;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             accept;
    logic             main_free;

    always_comb begin
        sel_val = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (selector == SELW'(k)) begin
                sel_val = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready  = !skid_valid && !reset;
    assign accept    = in_valid && in_ready;
    // Main register can take a new word when it is empty or being consumed this cycle.
    assign main_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            out_zero   <= 1'b1;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                data_out   <= skid_data;
                out_zero   <= (skid_data == '0);
                out_valid  <= 1'b1;
                skid_valid <= accept;
                if (accept) begin
                    skid_data <= sel_val;
                end
            end else if (accept) begin
                data_out  <= sel_val;
                out_zero  <= (sel_val == '0);
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= sel_val;
            skid_valid <= 1'b1;
        end
    end

`ifdef ALU_SRC_SELERR_EN
    localparam logic [SELW-1:0] NSRC_CODE = SELW'(NSRC);

    // Code NSRC is the one legal zero select; anything above it flags an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (accept && (selector > NSRC_CODE)) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_src_sel_pipe.sv
// Directed, table-driven bench for alu_src_sel_pipe (WIDTH=32, NSRC=2, SELW=2).
// Sticky-error sequence is built only when ALU_SRC_SELERR_EN is defined.
module tb_alu_src_sel_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  selector;
    logic [31:0] src0, src1;
    logic [63:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        out_zero;
`ifdef ALU_SRC_SELERR_EN
    logic        sel_err;
`endif

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;
    assign data_in = {src1, src0};

    alu_src_sel_pipe #(.WIDTH(32), .NSRC(2), .SELW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .selector  (selector),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_zero  (out_zero)
`ifdef ALU_SRC_SELERR_EN
        ,
        .sel_err   (sel_err)
`endif
    );

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic [31:0] s0;
        logic [31:0] s1;
        logic        ordy;
        logic        ev;
        logic [31:0] ed;
        logic        ez;
        logic        er;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; selector = 2'd0;
        src0 = 32'h5; src1 = 32'h0; out_ready = 1'b1;

        // reset held two cycles with in_valid asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_data_out",  data_out, 32'd0);
            chk("rst_out_zero",  {31'd0, out_zero}, 32'd1);
            chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // selection (rows 0-4) then backpressure A,B,C (rows 5-10)
        vt[0]  = '{1'b1, 2'd0, 32'hDEADBEEF, 32'h4, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
        vt[1]  = '{1'b1, 2'd1, 32'hDEADBEEF, 32'h4, 1'b1, 1'b1, 32'h4,        1'b0, 1'b1};
        vt[2]  = '{1'b1, 2'd2, 32'hDEADBEEF, 32'h4, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1};
        vt[3]  = '{1'b1, 2'd3, 32'hDEADBEEF, 32'h4, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1};
        vt[4]  = '{1'b0, 2'd0, 32'h0,        32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
        vt[5]  = '{1'b1, 2'd0, 32'hAAAA0001, 32'h0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 2'd0, 32'hBBBB0002, 32'h0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 2'd0, 32'hCCCC0003, 32'h0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 2'd0, 32'hCCCC0003, 32'h0, 1'b1, 1'b1, 32'hBBBB0002, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 2'd0, 32'hCCCC0003, 32'h0, 1'b1, 1'b1, 32'hCCCC0003, 1'b0, 1'b1};
        vt[10] = '{1'b0, 2'd0, 32'h0,        32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};

        for (int i = 0; i < 11; i++) begin
            in_valid = vt[i].iv; selector = vt[i].sel;
            src0 = vt[i].s0; src1 = vt[i].s1; out_ready = vt[i].ordy;
            tick();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].ev});
            chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vt[i].er});
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_data_out", i), data_out, vt[i].ed);
                chk($sformatf("vec%0d_out_zero", i), {31'd0, out_zero}, {31'd0, vt[i].ez});
            end
        end

        // full rate: 16 back-to-back words, no bubbles
        out_ready = 1'b1; selector = 2'd0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; src0 = 32'h100 + i;
            #1;
            chk($sformatf("fr%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            chk($sformatf("fr%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("fr%0d_data_out", i), data_out, 32'h100 + i);
        end
        in_valid = 1'b0;
        tick();
        chk("fr_drain_valid", {31'd0, out_valid}, 32'd0);

        // reset with main and skid both full
        out_ready = 1'b0; in_valid = 1'b1;
        src0 = 32'h1000; tick();
        src0 = 32'h2000; tick();
        chk("mid_full_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0; reset = 1'b1; tick();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_zero",  {31'd0, out_zero}, 32'd1);
        reset = 1'b0; in_valid = 1'b1; src0 = 32'h3000; tick();
        chk("mid_first_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_first_data",  data_out, 32'h3000);
        in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("mid_no_stale", {31'd0, out_valid}, 32'd0);

`ifdef ALU_SRC_SELERR_EN
        reset = 1'b1; tick();
        chk("se_rst", {31'd0, sel_err}, 32'd0);
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; selector = 2'd2; tick();
        chk("se_sel2_legal", {31'd0, sel_err}, 32'd0);
        selector = 2'd3; tick();
        chk("se_sel3_data", data_out, 32'd0);
        chk("se_sel3_err",  {31'd0, sel_err}, 32'd1);
        selector = 2'd0; src0 = 32'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("se_sticky%0d", i), {31'd0, sel_err}, 32'd1);
        end
        in_valid = 1'b0; reset = 1'b1; tick();
        chk("se_cleared", {31'd0, sel_err}, 32'd0);
        reset = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
